gfx_shadow_regfile: RTL and testbench
=====================================

Name: gfx_shadow_regfile

Overview:
Parametrised double-buffered register bank between the CPU data bus and the graphics renderers (paddles, ball, frame/score).
- CPU writes land in a shadow bank.
- The whole bank is copied atomically into a live bank at frame end, so renderers never see a torn frame.
- Adds over the previous generation: per-register dirty tracking, a readable status word, commit hold/defer, and a generalised auto-step register.

Parameters:
NUM_REGS, 10, number of shadow/live registers (1..2**ADDR_W-1)
DATA_W, 16, register and bus width
ADDR_W, 4, bus address width
RST_VALS, {320,240,320,240,320,240,0,0,0,0} packed NUM_REGS*DATA_W, per-register reset value (index 0 in LSBs)
AUTO_EN, 1, enables auto-step of register AUTO_IDX at each commit
AUTO_IDX, 6, index of auto-stepped register
AUTO_STEP, 10, increment per commit
AUTO_MAX, 999, step applies while value < AUTO_MAX, else value wraps to 0

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
chipselect  in  1  bus select
read  in  1  1 = read, 0 = write (qualified by chipselect)
data_address  in  ADDR_W  register address
wdata  in  DATA_W  write data
rdata  out  DATA_W  registered read data, 0 when not valid
rdata_valid  out  1  one-cycle pulse, rdata is valid
frame_end  in  1  one-cycle pulse on the last visible pixel (639,479) while VGA ready
hold  in  1  defers commit while high
live_regs  out  NUM_REGS*DATA_W  live bank to renderers, index 0 in LSBs
dirty  out  NUM_REGS  shadow differs from live due to bus write since last commit
commit_pulse  out  1  high for one cycle, the cycle after live_regs updates

Behaviour:
Reset (rst low, asynchronous):
- Shadow and live banks load RST_VALS.
- dirty = 0, pending = 0, rdata = 0, rdata_valid = 0, commit_pulse = 0.
- Deassertion is sampled on clk.

Write (chipselect & ~read):
- If data_address < NUM_REGS: shadow[addr] <= wdata and dirty[addr] <= 1 on the next edge.
- Addresses >= NUM_REGS are ignored; no state changes.

Read (chipselect & read), 1-cycle latency:
- Next edge: rdata_valid = 1.
- addr < NUM_REGS: rdata = shadow[addr].
- addr == NUM_REGS (STATUS): rdata = {zero pad, pending, dirty[NUM_REGS-1:0]}, with pending at bit NUM_REGS.
- Any other address: rdata = 0.
- No chipselect: rdata = 0, rdata_valid = 0.
- Top level owns any tri-state drive.

Commit trigger:
- commit_req = (frame_end | pending) & ~hold.
- frame_end & hold sets pending = 1.
- pending clears on the commit edge.
- Multiple held frame_ends collapse into one commit.

Commit edge:
- live <= shadow (values before any same-cycle write).
- dirty <= 0, except an index written in the same cycle, which stays 1.
- commit_pulse = 1 on the following cycle.

Auto-step (AUTO_EN = 1), applied on every commit edge:
- shadow[AUTO_IDX] <= (shadow < AUTO_MAX) ? shadow + AUTO_STEP : 0.
- Sum is truncated to DATA_W (modular).
- live gets the pre-step value.
- A same-cycle bus write to AUTO_IDX wins over the step.
- Auto-step does not set dirty.

Other rules:
- No write or read is ever stalled.
- Commit is the only path that changes live_regs.
- Reset mid-frame or mid-hold discards pending.

Decomposition:
- Package gfx_regs_pkg holds:
  - default parameter values;
  - address constants PADDLE_1_X=0, PADDLE_1_Y=1, PADDLE_2_X=2, PADDLE_2_Y=3, BALL_X=4, BALL_Y=5, BALL_Z=6, P1_SCORE=7, P2_SCORE=8, GAME_STATE=9, STATUS=NUM_REGS;
  - a function returning the default RST_VALS vector.
- One sub-module, gfx_auto_step: combinational next-value logic (compare, add, wrap) for the auto-stepped register, reused by future animated fields.

Test Plan:
- Reset then read addr 0..9 -> rdata 320,240,320,240,320,240,0,0,0,0 one cycle after each request; live_regs equals RST_VALS; dirty=0.
- Write addr 4 = 100, no frame_end -> live ball_x stays 320, dirty[4]=1, STATUS read = 0x0010; pulse frame_end -> live ball_x=100 next cycle, commit_pulse following cycle, dirty=0.
- Set shadow[6]=995, then two commits -> live[6]=995 then 1005 (shadow 1005 after first commit, 0 after second), third commit -> live[6]=0.
- hold=1, frame_end pulsed twice -> no live change, STATUS bit 10 (pending)=1; drop hold -> exactly one commit, pending=0.
- Write addr 2 = 55 in the same cycle as frame_end -> live[2] keeps its old value, shadow[2]=55, dirty[2] stays 1; a same-cycle write to addr 6 overrides auto-step.
- Write/read addr 11..15 -> no state change, rdata=0 with rdata_valid=1; assert rst mid-hold -> all banks at RST_VALS, pending=0 immediately without a clock edge.

Source files
------------

// File: rtl/gfx_regs_pkg.sv
// Shared defaults, register map and reset-value helper for the graphics shadow register bank.
package gfx_regs_pkg;

  localparam int unsigned DefNumRegs = 10;
  localparam int unsigned DefDataW   = 16;
  localparam int unsigned DefAddrW   = 4;
  localparam bit          DefAutoEn  = 1'b1;
  localparam int unsigned DefAutoStep = 10;
  localparam int unsigned DefAutoMax  = 999;

  localparam int unsigned PADDLE_1_X = 0;
  localparam int unsigned PADDLE_1_Y = 1;
  localparam int unsigned PADDLE_2_X = 2;
  localparam int unsigned PADDLE_2_Y = 3;
  localparam int unsigned BALL_X     = 4;
  localparam int unsigned BALL_Y     = 5;
  localparam int unsigned BALL_Z     = 6;
  localparam int unsigned P1_SCORE   = 7;
  localparam int unsigned P2_SCORE   = 8;
  localparam int unsigned GAME_STATE = 9;
  localparam int unsigned STATUS     = DefNumRegs;

  localparam int unsigned DefAutoIdx = BALL_Z;

  // Paddles and ball start centred on a 640x480 screen; scores and state start at zero.
  function automatic logic [DefNumRegs*DefDataW-1:0] default_rst_vals();
    logic [DefNumRegs*DefDataW-1:0] v;
    v = '0;
    v[PADDLE_1_X*DefDataW +: DefDataW] = DefDataW'(320);
    v[PADDLE_1_Y*DefDataW +: DefDataW] = DefDataW'(240);
    v[PADDLE_2_X*DefDataW +: DefDataW] = DefDataW'(320);
    v[PADDLE_2_Y*DefDataW +: DefDataW] = DefDataW'(240);
    v[BALL_X*DefDataW +: DefDataW]     = DefDataW'(320);
    v[BALL_Y*DefDataW +: DefDataW]     = DefDataW'(240);
    return v;
  endfunction

endpackage

// File: rtl/gfx_auto_step.sv
// Next-value logic for an animated register: add a fixed step below a ceiling, else wrap to 0.
module gfx_auto_step #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned AUTO_STEP = 10,
  parameter int unsigned AUTO_MAX  = 999
) (
  input  logic [DATA_W-1:0] cur_val,
  output logic [DATA_W-1:0] next_val
);

  localparam logic [DATA_W-1:0] Step = DATA_W'(AUTO_STEP);
  localparam logic [DATA_W-1:0] Max  = DATA_W'(AUTO_MAX);

  // Sum is intentionally modular in DATA_W.
  always_comb begin
    if (cur_val < Max) begin
      next_val = cur_val + Step;
    end else begin
      next_val = '0;
    end
  end

endmodule

// File: rtl/gfx_shadow_regfile.sv
// Double-buffered CPU-to-renderer register bank: bus writes hit the shadow bank, which is
// copied atomically into the live bank on frame end (deferrable by hold).
module gfx_shadow_regfile
  import gfx_regs_pkg::*;
#(
  parameter int unsigned NUM_REGS  = DefNumRegs,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VALS = default_rst_vals(),
  parameter bit          AUTO_EN   = DefAutoEn,
  parameter int unsigned AUTO_IDX  = DefAutoIdx,
  parameter int unsigned AUTO_STEP = DefAutoStep,
  parameter int unsigned AUTO_MAX  = DefAutoMax
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       chipselect,
  input  logic                       read,
  input  logic [ADDR_W-1:0]          data_address,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       rdata_valid,
  input  logic                       frame_end,
  input  logic                       hold,
  output logic [NUM_REGS*DATA_W-1:0] live_regs,
  output logic [NUM_REGS-1:0]        dirty,
  output logic                       commit_pulse
);

  localparam logic [ADDR_W-1:0] StatusAddr = ADDR_W'(NUM_REGS);
  localparam int unsigned       AutoIdx    = (AUTO_IDX < NUM_REGS) ? AUTO_IDX : 0;

  logic [NUM_REGS*DATA_W-1:0] shadow_q, shadow_d;
  logic [NUM_REGS*DATA_W-1:0] live_q;
  logic [NUM_REGS-1:0]        dirty_q, dirty_d;
  logic                       pending_q, pending_d;
  logic [DATA_W-1:0]          rdata_q, rdata_d;
  logic                       rdata_valid_q;
  logic                       commit_pulse_q;

  logic                       wr_en, rd_en, commit_req;
  logic [DATA_W-1:0]          status_word;
  logic [DATA_W-1:0]          auto_next;

  assign wr_en      = chipselect & ~read;
  assign rd_en      = chipselect & read;
  assign commit_req = (frame_end | pending_q) & ~hold;

  gfx_auto_step #(
    .DATA_W    (DATA_W),
    .AUTO_STEP (AUTO_STEP),
    .AUTO_MAX  (AUTO_MAX)
  ) u_auto_step (
    .cur_val  (shadow_q[AutoIdx*DATA_W +: DATA_W]),
    .next_val (auto_next)
  );

  always_comb begin
    status_word                = '0;
    status_word[NUM_REGS-1:0]  = dirty_q;
    status_word[NUM_REGS]      = pending_q;
  end

  // Any held frame_end collapses into a single deferred commit.
  always_comb begin
    pending_d = pending_q;
    if (commit_req) begin
      pending_d = 1'b0;
    end else if (frame_end & hold) begin
      pending_d = 1'b1;
    end
  end

  // Commit effects first, then a same-cycle bus write overrides them for its index.
  always_comb begin
    shadow_d = shadow_q;
    dirty_d  = dirty_q;
    if (commit_req) begin
      dirty_d = '0;
      if (AUTO_EN) begin
        shadow_d[AutoIdx*DATA_W +: DATA_W] = auto_next;
      end
    end
    if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (data_address == ADDR_W'(i)) begin
          shadow_d[i*DATA_W +: DATA_W] = wdata;
          dirty_d[i]                   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (data_address == ADDR_W'(i)) begin
          rdata_d = shadow_q[i*DATA_W +: DATA_W];
        end
      end
      if (data_address == StatusAddr) begin
        rdata_d = status_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q       <= RST_VALS;
      live_q         <= RST_VALS;
      dirty_q        <= '0;
      pending_q      <= 1'b0;
      rdata_q        <= '0;
      rdata_valid_q  <= 1'b0;
      commit_pulse_q <= 1'b0;
    end else begin
      shadow_q       <= shadow_d;
      dirty_q        <= dirty_d;
      pending_q      <= pending_d;
      rdata_q        <= rdata_d;
      rdata_valid_q  <= rd_en;
      commit_pulse_q <= commit_req;
      if (commit_req) begin
        live_q <= shadow_q;
      end
    end
  end

  assign live_regs    = live_q;
  assign dirty        = dirty_q;
  assign rdata        = rdata_q;
  assign rdata_valid  = rdata_valid_q;
  assign commit_pulse = commit_pulse_q;

endmodule

// File: tb/tb_gfx_shadow_regfile.sv
// Self-checking bench: directed literal checks plus randomized traffic against an array model.
module tb_gfx_shadow_regfile;
  import gfx_regs_pkg::*;

  localparam int N = 10;
  localparam int W = 16;
  localparam int A = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           chipselect = 1'b0;
  logic           read = 1'b0;
  logic [A-1:0]   data_address = '0;
  logic [W-1:0]   wdata = '0;
  logic           frame_end = 1'b0;
  logic           hold = 1'b0;
  logic [W-1:0]   rdata;
  logic           rdata_valid;
  logic [N*W-1:0] live_regs;
  logic [N-1:0]   dirty;
  logic           commit_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gfx_shadow_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .chipselect   (chipselect),
    .read         (read),
    .data_address (data_address),
    .wdata        (wdata),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .frame_end    (frame_end),
    .hold         (hold),
    .live_regs    (live_regs),
    .dirty        (dirty),
    .commit_pulse (commit_pulse)
  );

  int rst_tab[N] = '{320, 240, 320, 240, 320, 240, 0, 0, 0, 0};

  // Behavioural model: plain arrays updated with the bank's rules at every clock edge.
  int m_sh[N];
  int m_live[N];
  bit m_dirty[N];
  bit m_pend;
  int m_rdata;
  bit m_valid;
  bit m_pulse;

  function automatic int model_status();
    int s = 0;
    for (int i = 0; i < N; i++) if (m_dirty[i]) s = s | (1 << i);
    if (m_pend) s = s | (1 << N);
    return s;
  endfunction

  function automatic int model_read(input int a);
    if (a < N) return m_sh[a];
    if (a == N) return model_status();
    return 0;
  endfunction

  function automatic int model_dirty();
    int d = 0;
    for (int i = 0; i < N; i++) if (m_dirty[i]) d = d | (1 << i);
    return d;
  endfunction

  wire m_commit = (frame_end | m_pend) & ~hold;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        m_sh[i]    <= rst_tab[i];
        m_live[i]  <= rst_tab[i];
        m_dirty[i] <= 1'b0;
      end
      m_pend  <= 1'b0;
      m_rdata <= 0;
      m_valid <= 1'b0;
      m_pulse <= 1'b0;
    end else begin
      m_valid <= chipselect & read;
      m_rdata <= (chipselect & read) ? model_read(int'(data_address)) : 0;
      m_pulse <= m_commit;
      if (m_commit) begin
        for (int i = 0; i < N; i++) begin
          m_live[i]  <= m_sh[i];
          m_dirty[i] <= 1'b0;
        end
        m_sh[6] <= (m_sh[6] < 999) ? ((m_sh[6] + 10) & 16'hFFFF) : 0;
        m_pend  <= 1'b0;
      end else if (frame_end & hold) begin
        m_pend <= 1'b1;
      end
      if (chipselect & ~read & (int'(data_address) < N)) begin
        m_sh[int'(data_address)]    <= int'(wdata);
        m_dirty[int'(data_address)] <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) chk($sformatf("live[%0d]", i), int'(live_regs[i*W +: W]), m_live[i]);
    chk("dirty", int'(dirty), model_dirty());
    chk("rdata", int'(rdata), m_rdata);
    chk("rdata_valid", int'(rdata_valid), int'(m_valid));
    chk("commit_pulse", int'(commit_pulse), int'(m_pulse));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input int a, input int d);
    data_address = A'(a);
    wdata        = W'(d);
    chipselect   = 1'b1;
    read         = 1'b0;
    step();
    chipselect   = 1'b0;
  endtask

  task automatic bus_rd(input int a, input int exp, input string nm);
    data_address = A'(a);
    chipselect   = 1'b1;
    read         = 1'b1;
    step();
    chipselect   = 1'b0;
    read         = 1'b0;
    chk(nm, int'(rdata), exp);
    chk({nm, "_valid"}, int'(rdata_valid), 1);
  endtask

  task automatic pulse_fe();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
  endtask

  function automatic int live_at(input int i);
    return int'(live_regs[i*W +: W]);
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) chk("reset_live", live_at(i), rst_tab[i]);
    chk("reset_dirty", int'(dirty), 0);
    rst = 1'b1;
    step();

    for (int i = 0; i < N; i++) bus_rd(i, rst_tab[i], $sformatf("reset_rd%0d", i));

    bus_wr(4, 100);
    chk("ballx_not_live", live_at(4), 320);
    chk("dirty4", int'(dirty), 'h010);
    bus_rd(STATUS, 'h0010, "status_dirty4");
    pulse_fe();
    chk("ballx_live", live_at(4), 100);
    chk("pulse_hi", int'(commit_pulse), 1);
    chk("dirty_clr", int'(dirty), 0);
    step();
    chk("pulse_lo", int'(commit_pulse), 0);

    bus_wr(6, 995);
    pulse_fe();
    chk("z_live1", live_at(6), 995);
    bus_rd(6, 1005, "z_sh1");
    pulse_fe();
    chk("z_live2", live_at(6), 1005);
    bus_rd(6, 0, "z_sh2");
    pulse_fe();
    chk("z_live3", live_at(6), 0);

    hold = 1'b1;
    pulse_fe();
    step();
    pulse_fe();
    chk("held_live6", live_at(6), 0);
    chk("held_pulse", int'(commit_pulse), 0);
    bus_rd(STATUS, 'h0400, "status_pending");
    hold = 1'b0;
    step();
    chk("release_pulse", int'(commit_pulse), 1);
    chk("release_live6", live_at(6), 10);
    step();
    chk("single_commit", int'(commit_pulse), 0);
    bus_rd(STATUS, 0, "status_clear");

    frame_end = 1'b1;
    bus_wr(2, 55);
    frame_end = 1'b0;
    chk("wr_fe_live2", live_at(2), 320);
    chk("wr_fe_dirty", int'(dirty), 'h004);
    bus_rd(2, 55, "wr_fe_sh2");
    frame_end = 1'b1;
    bus_wr(6, 500);
    frame_end = 1'b0;
    chk("wr_fe_live6", live_at(6), 30);
    chk("wr_fe_dirty6", int'(dirty), 'h040);
    bus_rd(6, 500, "wr_beats_step");

    for (int a = N; a < 16; a++) bus_wr(a, int'($urandom_range(0, 65535)));
    chk("oob_dirty", int'(dirty), 'h040);
    for (int a = N + 1; a < 16; a++) bus_rd(a, 0, $sformatf("oob_rd%0d", a));

    hold = 1'b1;
    pulse_fe();
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < N; i++) chk("async_live", live_at(i), rst_tab[i]);
    chk("async_dirty", int'(dirty), 0);
    chk("async_pulse", int'(commit_pulse), 0);
    step();
    rst = 1'b1;
    hold = 1'b0;
    step();
    chk("no_commit_after_rst", int'(commit_pulse), 0);
    bus_rd(STATUS, 0, "status_after_rst");

    for (int c = 0; c < 3000; c++) begin
      chipselect   = 1'($urandom_range(0, 1));
      read         = 1'($urandom_range(0, 1));
      data_address = A'($urandom_range(0, 15));
      wdata        = W'($urandom);
      if ($urandom_range(0, 3) == 0) wdata = W'(985 + $urandom_range(0, 20));
      if ($urandom_range(0, 3) == 0) data_address = A'(6);
      frame_end    = ($urandom_range(0, 7) == 0);
      hold         = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #1;
        rst = 1'b0;
        #1;
        rst = 1'b1;
      end
      step();
    end
    chipselect = 1'b0;
    frame_end  = 1'b0;
    hold       = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
